// File: rtl/param_shift_engine.sv
// Multi-cycle shift engine: moves a WIDTH-bit register by Amt positions,
// at most STEP positions per clock, with Start/Busy/Done handshaking.
module param_shift_engine #(
    parameter int WIDTH = 8,
    parameter int STEP  = 2,
    parameter int AMT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Load,
    input  logic [WIDTH-1:0] din,
    input  logic             Start,
    input  logic             Dir,
    input  logic [1:0]       Mode,
    input  logic [AMT_W-1:0] Amt,
    input  logic             SIn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] dout,
    output logic             SOut
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [AMT_W-1:0] rem;
    logic             dir_reg;
    logic [1:0]       mode_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             sout_reg;

    int               step_sz;
    logic [WIDTH:0]   step_res;

    // One step of s positions; returns {bit shifted out last, new value}.
    function automatic logic [WIDTH:0] step_shift(
        input logic [WIDTH-1:0] val,
        input int               s,
        input logic             dir,
        input logic [1:0]       mode,
        input logic             sin
    );
        logic [2*WIDTH-1:0] dbl;
        logic [WIDTH-1:0]   res;
        logic [WIDTH-1:0]   fill_mask;
        logic [WIDTH-1:0]   probe;
        dbl = {val, val};
        if (!dir) begin
            fill_mask = ~({WIDTH{1'b1}} << s);
            probe     = val >> (WIDTH - s);
            case (mode)
                2'b10: begin
                    dbl = dbl << s;
                    res = dbl[2*WIDTH-1:WIDTH];
                end
                2'b11:   res = (val << s) | (sin ? fill_mask : '0);
                default: res = val << s;
            endcase
        end else begin
            fill_mask = ~({WIDTH{1'b1}} >> s);
            probe     = val >> (s - 1);
            case (mode)
                2'b01:   res = $signed(val) >>> s;
                2'b10: begin
                    dbl = dbl >> s;
                    res = dbl[WIDTH-1:0];
                end
                2'b11:   res = (val >> s) | (sin ? fill_mask : '0);
                default: res = val >> s;
            endcase
        end
        return {probe[0], res};
    endfunction

    always_comb begin
        step_sz  = (int'(rem) < STEP) ? int'(rem) : STEP;
        step_res = step_shift(shift_reg, step_sz, dir_reg, mode_reg, SIn);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            shift_reg <= '0;
            rem       <= '0;
            dir_reg   <= 1'b0;
            mode_reg  <= 2'b00;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sout_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (Load) begin
                        shift_reg <= din;
                        state     <= IDLE;
                    end else if (Start && (Amt != '0)) begin
                        dir_reg  <= Dir;
                        mode_reg <= Mode;
                        rem      <= Amt;
                        busy_reg <= 1'b1;
                        state    <= SHIFT;
                    end else if (Start) begin
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    shift_reg <= step_res[WIDTH-1:0];
                    sout_reg  <= step_res[WIDTH];
                    rem       <= rem - AMT_W'(step_sz);
                    // Final step: the result and Done land on the same edge.
                    if (rem == AMT_W'(step_sz)) begin
                        busy_reg <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Busy = busy_reg;
    assign Done = done_reg;
    assign dout = shift_reg;
    assign SOut = sout_reg;

endmodule
